sev_seg_scanner: RTL and testbench

SEV_SEG_SCANNER -- requirements
Module: sev_seg_scanner

---
 rtl/sev_seg_pkg.sv | 29 ++
 rtl/sev_seg_decoder.sv | 11 +
 rtl/sev_seg_scanner.sv | 142 ++++++++++++++
 tb/tb_sev_seg_scanner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Used by sev_seg_scanner and sev_seg_decoder.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned BRIGHT_W = 4;

  // Active-low {g,f,e,d,c,b,a}; element n is the pattern for hex digit n.
  localparam seg_t [15:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/sev_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sev_seg_decoder
  import sev_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/sev_seg_scanner.sv
// Multiplexed seven-segment scanner with double-buffered display data.
// Optional brightness PWM enabled by defining SEV_SEG_BRIGHTNESS_EN.
module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lzb,
`ifdef SEV_SEG_BRIGHTNESS_EN
  input  logic [BRIGHT_W-1:0]   brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] act_val_q, act_val_d, pend_val_q;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_start_q;
  logic                  tick, wrap, duty_on, lit, zero_run;
  logic [N_DIGITS-1:0]   lzb_blank;
  logic [3:0]            nib;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_valid_d = pend_valid_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    // A load landing on the wrap bypasses the pending buffer entirely.
    if (wrap && load) begin
      act_val_d    = value;
      act_dp_d     = dp;
      pend_valid_d = 1'b0;
    end else if (wrap && pend_valid_q) begin
      act_val_d    = pend_val_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero run from the most significant digit down; digit 0 always shows.
  always_comb begin
    zero_run  = 1'b1;
    lzb_blank = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run     = zero_run && (act_val_d[4*i +: 4] == 4'h0);
      lzb_blank[i] = zero_run && (i != 0);
    end
  end

`ifdef SEV_SEG_BRIGHTNESS_EN
  localparam logic [CNT_W-1:0] PHASE_LEN = CNT_W'(REFRESH_DIV / 16);
  logic [CNT_W-1:0] slot_pos;

  // Phases are counted from the end of the dead-time cycle so level 15 gives 15/16 duty.
  always_comb begin
    slot_pos = cnt_d - CNT_W'(1);
    duty_on  = !tick && ((slot_pos / PHASE_LEN) < CNT_W'(brightness));
  end
`else
  assign duty_on = !tick;
`endif

  assign nib = act_val_d[4*idx_d +: 4];

  sev_seg_decoder u_decoder (
    .nib (nib),
    .seg (seg_d)
  );

  always_comb begin
    lit    = duty_on && digit_en[idx_d] && !(lzb && lzb_blank[idx_d]);
    an_d   = '1;
    dp_n_d = 1'b1;
    if (lit) begin
      an_d[idx_d] = 1'b0;
      dp_n_d      = ~act_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      seg_q         <= 7'b1111111;
      dp_n_q        <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      pend_valid_q  <= pend_valid_d;
      if (load) begin
        pend_val_q <= value;
        pend_dp_q  <= dp;
      end
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_q          <= an_d;
      frame_start_q <= wrap;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Directed self-checking bench for sev_seg_scanner (N_DIGITS=4, REFRESH_DIV=16).
module tb_sev_seg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        lzb = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lit_cnt;

  sev_seg_scanner #(
    .N_DIGITS    (4),
    .REFRESH_DIV (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp          (dp),
    .digit_en    (digit_en),
    .lzb         (lzb),
`ifdef SEV_SEG_BRIGHTNESS_EN
    .brightness  (bright),
`endif
    .seg         (seg),
    .dp_n        (dp_n),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cyc counts rising edges since reset release; sampling happens on falling edges.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int m);
    while (cyc < m) step();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_frame_start", frame_start, 1'b0);
    rst = 1'b0;
    cyc = 0;

    // Blank-buffer scan: digits 0..3, 16 cycles each, one dead cycle per slot
    go_to(1);   chk("scan_m1_an", an, 4'b1110);
                chk("scan_m1_seg", seg, 7'b1000000);
    go_to(15);  chk("scan_m15_an", an, 4'b1110);
    go_to(16);  chk("scan_m16_dead", an, 4'b1111);
    go_to(17);  chk("scan_m17_an", an, 4'b1101);
    go_to(33);  chk("scan_m33_an", an, 4'b1011);
    go_to(49);  chk("scan_m49_an", an, 4'b0111);
    go_to(63);  chk("scan_m63_fs", frame_start, 1'b0);
    go_to(64);  chk("scan_m64_fs", frame_start, 1'b1);
                chk("scan_m64_dead", an, 4'b1111);
    go_to(65);  chk("scan_m65_fs", frame_start, 1'b0);
                chk("scan_m65_an", an, 4'b1110);

    // Mid-frame load is held pending until the wrap at edge 128
    go_to(70);  load = 1'b1; value = 16'h12AF; dp = 4'b0001;
    step();     load = 1'b0; value = 16'h0000; dp = 4'b0000;
    go_to(72);  chk("pend_m72_seg", seg, 7'b1000000);
                chk("pend_m72_dp_n", dp_n, 1'b1);
    go_to(81);  chk("pend_m81_seg", seg, 7'b1000000);
    go_to(128); chk("wrap_m128_seg", seg, 7'b0001110);
                chk("wrap_m128_dp_n", dp_n, 1'b1);
                chk("wrap_m128_an", an, 4'b1111);
    go_to(129); chk("new_d0_seg", seg, 7'b0001110);
                chk("new_d0_dp_n", dp_n, 1'b0);
    go_to(145); chk("new_d1_seg", seg, 7'b0001000);
                chk("new_d1_dp_n", dp_n, 1'b1);
    go_to(177); chk("new_d3_seg", seg, 7'b1111001);
                chk("new_d3_an", an, 4'b0111);

    // Load coincident with the wrap goes straight to the display
    go_to(191); load = 1'b1; value = 16'h3456;
    step();     load = 1'b0; value = 16'h0000; digit_en = 4'b1011;
    chk("bypass_m192_seg", seg, 7'b0000010);
    go_to(193); chk("bypass_m193_an", an, 4'b1110);
                chk("bypass_m193_dp_n", dp_n, 1'b1);
    go_to(209); chk("bypass_d1_seg", seg, 7'b0010010);
    go_to(225); chk("en_d2_off_a", an, 4'b1111);
    go_to(233); chk("en_d2_off_b", an, 4'b1111);
    go_to(241); chk("en_d3_an", an, 4'b0111);
                chk("en_d3_seg", seg, 7'b0110000);
    go_to(255); digit_en = 4'hF;

    // Leading-zero blanking
    go_to(260); load = 1'b1; value = 16'h0005;
    step();     load = 1'b0;
    go_to(300); lzb = 1'b1;
    go_to(321); chk("lzb5_d0_an", an, 4'b1110);
                chk("lzb5_d0_seg", seg, 7'b0010010);
    go_to(337); chk("lzb5_d1_an", an, 4'b1111);
    go_to(353); chk("lzb5_d2_an", an, 4'b1111);
    go_to(369); chk("lzb5_d3_an", an, 4'b1111);
    go_to(370); load = 1'b1; value = 16'h0000;
    step();     load = 1'b0;
    go_to(385); chk("lzb0_d0_an", an, 4'b1110);
                chk("lzb0_d0_seg", seg, 7'b1000000);
    go_to(401); chk("lzb0_d1_an", an, 4'b1111);
    go_to(402); load = 1'b1; value = 16'h0105;
    step();     load = 1'b0;
    go_to(465); chk("lzb105_d1_an", an, 4'b1101);
                chk("lzb105_d1_seg", seg, 7'b1000000);
    go_to(481); chk("lzb105_d2_an", an, 4'b1011);
    go_to(497); chk("lzb105_d3_an", an, 4'b1111);
    go_to(500); lzb = 1'b0;
    go_to(505); chk("nolzb_d3_an", an, 4'b0111);

    // Asynchronous reset mid-slot, then restart from digit 0
    #2 rst = 1'b1;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'b1111111);
    chk("arst_dp_n", dp_n, 1'b1);
    chk("arst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    go_to(1);   chk("rel_m1_an", an, 4'b1110);
                chk("rel_m1_seg", seg, 7'b1000000);
    go_to(15);  chk("rel_m15_an", an, 4'b1110);
    go_to(16);  chk("rel_m16_dead", an, 4'b1111);
    go_to(17);  chk("rel_m17_an", an, 4'b1101);

`ifdef SEV_SEG_BRIGHTNESS_EN
    go_to(31);  bright = 4'd4;
    lit_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an != 4'hF) lit_cnt++;
    end
    chk("bright4_lit", lit_cnt, 4);
    bright = 4'd0;
    lit_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an != 4'hF) lit_cnt++;
    end
    chk("bright0_lit", lit_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
